// File: rtl/skew_feeder_pkg.sv
// rtl/skew_feeder_pkg.sv - shared defaults, FSM state type and beat-count helper
package systolic_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ROWS_DEF   = 4;
   localparam int COLS_DEF   = 4;

   typedef enum logic {IDLE, STREAM} feed_state_t;

   // A tile occupies the array edge for the diagonal span of its last row.
   function automatic int beats(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// rtl/skew_feeder_if.sv - tile handshake, stall and skewed row output bundle
interface skew_feeder_if
   import systolic_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic                        in_valid;
   logic                        in_ready;
   logic [ROWS*COLS*DATA_W-1:0] in_tile;
   logic                        en;
   logic [ROWS*DATA_W-1:0]      row_val;
   logic [ROWS-1:0]             row_vld;
   logic                        busy;
   logic                        tile_done;

   modport master (
      output in_valid, in_tile, en,
      input  in_ready, row_val, row_vld, busy, tile_done
   );

   modport slave (
      input  in_valid, in_tile, en,
      output in_ready, row_val, row_vld, busy, tile_done
   );

endinterface

// File: rtl/skew_feeder_row.sv
// rtl/skew_feeder_row.sv - picks element t-R of one row slice, zero outside the row's window
module skew_row
   import systolic_pkg::*;
#(
   parameter int R      = 0,
   parameter int COLS   = COLS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 3
) (
   input  logic [CNT_W-1:0]       t,
   input  logic [COLS*DATA_W-1:0] row_data,
   output logic [DATA_W-1:0]      val,
   output logic                   vld
);

   int k;

   always_comb begin
      val = '0;
      vld = 1'b0;
      k   = int'(t) - R;
      if (k >= 0 && k < COLS) begin
         vld = 1'b1;
         val = row_data[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - accepts activation tiles and streams rows with a diagonal skew
module skew_feeder
   import systolic_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   skew_feeder_if.slave bus
);

   localparam int BEATS = beats(ROWS, COLS);
   localparam int LAST  = BEATS - 1;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LAST);

   feed_state_t                 state_q, state_d;
   logic [CNT_W-1:0]            t_q, t_d;
   logic [ROWS*COLS*DATA_W-1:0] tile_q, tile_d;

   logic                        at_last;
   logic                        accept;
   logic [ROWS*DATA_W-1:0]      val_raw;
   logic [ROWS-1:0]             vld_raw;

   // The final beat is the only STREAM cycle that can take a new tile.
   assign at_last       = (state_q == STREAM) && bus.en && (t_q == T_LAST);
   assign bus.in_ready  = (state_q == IDLE) || at_last;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.tile_done = at_last;
   assign bus.busy      = (state_q == STREAM);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      tile_d  = tile_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = STREAM;
               tile_d  = bus.in_tile;
               t_d     = '0;
            end
         end
         STREAM: begin
            if (bus.en) begin
               if (t_q == T_LAST) begin
                  t_d = '0;
                  if (accept) begin
                     tile_d = bus.in_tile;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  t_d = t_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         t_q     <= '0;
         tile_q  <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         tile_q  <= tile_d;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      skew_row #(
         .R      (r),
         .COLS   (COLS),
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_row (
         .t        (t_q),
         .row_data (tile_q[r*COLS*DATA_W +: COLS*DATA_W]),
         .val      (val_raw[r*DATA_W +: DATA_W]),
         .vld      (vld_raw[r])
      );
   end

   // t rests at 0 in IDLE, so the row selects would otherwise expose element (0,0).
   assign bus.row_val = (state_q == STREAM) ? val_raw : '0;
   assign bus.row_vld = (state_q == STREAM) ? vld_raw : '0;

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - scoreboard bench for skew_feeder over three array shapes
module tb_skew_feeder;
   import systolic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   function automatic int cfg_rows(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 2;
   endfunction

   function automatic int cfg_cols(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 8;
   endfunction

   function automatic int cfg_dw(input int i);
      return (i == 2) ? 16 : 8;
   endfunction

   task automatic check(input string name, input int cfg, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cfg%0d @%0t: got %0h, expected %0h", name, cfg, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int R  = cfg_rows(g);
      localparam int C  = cfg_cols(g);
      localparam int D  = cfg_dw(g);
      localparam int BE = R + C - 1;

      logic           rst_n;
      bit             stim_done = 1'b0;
      logic [R*D-1:0] exp_val_q[$];
      logic [R-1:0]   exp_vld_q[$];

      skew_feeder_if #(.ROWS(R), .COLS(C), .DATA_W(D)) bus ();

      skew_feeder #(.ROWS(R), .COLS(C), .DATA_W(D)) dut (
         .clk   (clk),
         .reset (rst_n),
         .bus   (bus.slave)
      );

      // Stimulus: directed single/stall/back-to-back/reset phases, then random traffic.
      initial begin
         logic [R*C*D-1:0] tile;
         logic [R*D-1:0]   v;
         logic [R-1:0]     m;
         tile         = '0;
         rst_n        = 1'b0;
         bus.in_valid = 1'b0;
         bus.in_tile  = '0;
         bus.en       = 1'b0;
         for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            rst_n        = !(cyc < 4 || cyc == 75);
            bus.en       = 1'b1;
            bus.in_valid = 1'b0;
            if (cyc == 4 || cyc == 20 || cyc == 40 || cyc == 70) begin
               bus.in_valid = 1'b1;
               for (int r = 0; r < R; r++)
                  for (int k = 0; k < C; k++)
                     tile[(r*C+k)*D +: D] = D'(16*r + k + 1);
            end else if (cyc > 40 && cyc <= 40 + BE) begin
               bus.in_valid = 1'b1;
               for (int r = 0; r < R; r++)
                  for (int k = 0; k < C; k++)
                     tile[(r*C+k)*D +: D] = D'(128 + 16*r + k);
            end else if (cyc >= 80 && cyc < 480) begin
               bus.en       = ($urandom_range(0, 3) != 0);
               bus.in_valid = ($urandom_range(0, 1) == 1);
               for (int e = 0; e < R*C; e++)
                  tile[e*D +: D] = D'($urandom);
            end
            if (cyc >= 23 && cyc <= 25) bus.en = 1'b0;
            bus.in_tile = tile;
            #2;
            if (rst_n && bus.in_valid && bus.in_ready) begin
               for (int t = 0; t < BE; t++) begin
                  v = '0;
                  m = '0;
                  for (int r = 0; r < R; r++) begin
                     if (t - r >= 0 && t - r < C) begin
                        m[r]         = 1'b1;
                        v[r*D +: D]  = tile[(r*C + t - r)*D +: D];
                     end
                  end
                  exp_val_q.push_back(v);
                  exp_vld_q.push_back(m);
               end
            end
         end
         stim_done = 1'b1;
      end

      // Monitor: compares the presented beat with the scoreboard head every cycle.
      initial begin
         while (!stim_done) begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
               check("rst_row_val", g, 64'(bus.row_val), 64'(0));
               check("rst_row_vld", g, 64'(bus.row_vld), 64'(0));
               check("rst_busy", g, 64'(bus.busy), 64'(0));
               check("rst_tile_done", g, 64'(bus.tile_done), 64'(0));
               check("rst_in_ready", g, 64'(bus.in_ready), 64'(1));
               exp_val_q.delete();
               exp_vld_q.delete();
            end else begin
               int             n;
               bit             last;
               logic [R*D-1:0] ev;
               logic [R-1:0]   em;
               n    = exp_val_q.size();
               last = (n == 1) && bus.en;
               ev   = (n != 0) ? exp_val_q[0] : '0;
               em   = (n != 0) ? exp_vld_q[0] : '0;
               check("busy", g, 64'(bus.busy), 64'(n != 0));
               check("row_val", g, 64'(bus.row_val), 64'(ev));
               check("row_vld", g, 64'(bus.row_vld), 64'(em));
               check("tile_done", g, 64'(bus.tile_done), 64'(last));
               check("in_ready", g, 64'(bus.in_ready), 64'(n == 0 || last));
               if (n != 0 && bus.en) begin
                  void'(exp_val_q.pop_front());
                  void'(exp_vld_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         if (g_cfg[0].stim_done && g_cfg[1].stim_done && g_cfg[2].stim_done) break;
      end
      if (!(g_cfg[0].stim_done && g_cfg[1].stim_done && g_cfg[2].stim_done)) begin
         n_vec++;
         n_bad++;
         $display("FAIL timeout: stimulus not complete, expected completion within 2000 cycles");
      end
      repeat (2) @(posedge clk);
      check("drain", 0, 64'(g_cfg[0].exp_val_q.size()), 64'(0));
      check("drain", 1, 64'(g_cfg[1].exp_val_q.size()), 64'(0));
      check("drain", 2, 64'(g_cfg[2].exp_val_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
